// File: rtl/frame_line_sequencer.sv
// Per-frame line sequencer in front of the image core: prefill lines, then one line per core
// interrupt edge, then zero pad lines, then wait for the full output pixel count.
module frame_line_sequencer #(
    parameter int unsigned IMG_WIDTH     = 512,
    parameter int unsigned IMG_HEIGHT    = 512,
    parameter int unsigned PREFILL_LINES = 4,
    parameter int unsigned PAD_LINES     = 2,
    parameter int unsigned DATA_W        = 8
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] o_pix_data,
    output logic              o_pix_valid,
    output logic [1:0]        o_mode,
    input  logic              i_intr,
    input  logic              i_out_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int unsigned TotalPix = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned OutW     = $clog2(TotalPix + 1);
    localparam int unsigned BeatW    = $clog2(PREFILL_LINES * IMG_WIDTH + 1);
    localparam int unsigned LineW    = $clog2(IMG_HEIGHT + 1);
    localparam int unsigned PadW     = $clog2(PAD_LINES + 2);

    typedef enum logic [2:0] {
        StIdle, StPrefill, StWaitIntr, StLine, StPad, StDrain, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [BeatW-1:0]  beat_q;
    logic [LineW-1:0]  lines_q;
    logic [PadW-1:0]   pad_q;
    logic [OutW-1:0]   out_cnt_q;
    logic              intr_q, pend_q, err_q, pix_valid_q;
    logic [DATA_W-1:0] pix_data_q;
    logic [1:0]        mode_q;

    logic intr_edge, xfer, go, out_full, last_prefill, last_beat, in_burst, pad_final;

    assign intr_edge    = i_intr & ~intr_q;
    assign xfer         = s_valid & s_ready;
    assign go           = intr_edge | pend_q;
    assign out_full     = (out_cnt_q == OutW'(TotalPix));
    assign last_prefill = (beat_q == BeatW'(PREFILL_LINES * IMG_WIDTH - 1));
    assign last_beat    = (beat_q == BeatW'(IMG_WIDTH - 1));
    assign in_burst     = (state_q == StPrefill) || (state_q == StLine);
    assign pad_final    = ((pad_q + PadW'(1)) == PadW'(PAD_LINES));

    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (i_start) state_d = StPrefill;
            StPrefill:  if (xfer && last_prefill) state_d = StWaitIntr;
            StWaitIntr: begin
                if (go) begin
                    if (lines_q < LineW'(IMG_HEIGHT))   state_d = StLine;
                    else if (pad_q < PadW'(PAD_LINES))  state_d = StPad;
                    else                                state_d = StDrain;
                end
            end
            StLine:     if (xfer && last_beat) state_d = StWaitIntr;
            StPad:      if (last_beat) state_d = pad_final ? StDrain : StWaitIntr;
            StDrain:    if (out_full) state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Reset gates s_ready so a held s_valid is never consumed in the reset cycle.
    always_comb begin
        s_ready     = axi_reset_n & in_burst;
        o_busy      = (state_q != StIdle);
        o_done      = (state_q == StDone);
        o_pix_valid = pix_valid_q;
        o_pix_data  = pix_data_q;
        o_mode      = mode_q;
        o_err       = err_q;
    end

    always_ff @(posedge axi_clk) begin
        if (!axi_reset_n) begin
            beat_q      <= '0;
            lines_q     <= '0;
            pad_q       <= '0;
            out_cnt_q   <= '0;
            intr_q      <= 1'b0;
            pend_q      <= 1'b0;
            err_q       <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            mode_q      <= 2'd0;
        end else begin
            intr_q      <= i_intr;
            pix_valid_q <= 1'b0;
            if (xfer) begin
                pix_valid_q <= 1'b1;
                pix_data_q  <= s_data;
            end else if (state_q == StPad) begin
                pix_valid_q <= 1'b1;
                pix_data_q  <= '0;
            end

            if ((state_q != StIdle) && i_out_valid && !out_full) begin
                out_cnt_q <= out_cnt_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (i_start) begin
                        mode_q    <= i_mode;
                        beat_q    <= '0;
                        lines_q   <= '0;
                        pad_q     <= '0;
                        out_cnt_q <= '0;
                        err_q     <= 1'b0;
                        pend_q    <= 1'b0;
                    end
                end
                StPrefill: begin
                    if (xfer) begin
                        if (last_prefill) begin
                            beat_q  <= '0;
                            lines_q <= LineW'(PREFILL_LINES);
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                // A fresh edge arriving with pend set consumes one and leaves the other pending.
                StWaitIntr: if (go) pend_q <= intr_edge & pend_q;
                StLine: begin
                    if (xfer) begin
                        if (last_beat) begin
                            beat_q  <= '0;
                            lines_q <= lines_q + 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StPad: begin
                    if (last_beat) begin
                        beat_q <= '0;
                        pad_q  <= pad_q + 1'b1;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: ;
            endcase

            if (intr_edge && ((state_q == StPrefill) || (state_q == StLine) ||
                              (state_q == StPad))) begin
                if (pend_q) err_q  <= 1'b1;
                else        pend_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frame_line_sequencer.sv
// Directed bench for frame_line_sequencer with an 8x6 frame, 4 prefill lines and 2 pad lines.
module tb_frame_line_sequencer;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int PF = 4;
    localparam int PD = 2;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic [1:0]    mode_out;
    logic          intr = 1'b0;
    logic          out_valid = 1'b0;
    logic          busy, done, err;

    int n_total = 0;
    int n_bad = 0;
    int pv_cnt = 0, pv_zero = 0, xfer_cnt = 0, done_cnt = 0, lat_bad = 0;
    logic          prev_x = 1'b0;
    logic [DW-1:0] prev_d = '0;
    bit lat_en = 1'b0;
    bit toggle = 1'b0;
    int x0, p0, z0;

    frame_line_sequencer #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PREFILL_LINES(PF), .PAD_LINES(PD), .DATA_W(DW)
    ) dut (
        .axi_clk(clk), .axi_reset_n(rst_n), .i_start(start), .i_mode(mode),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .o_pix_data(pix_data), .o_pix_valid(pix_valid), .o_mode(mode_out),
        .i_intr(intr), .i_out_valid(out_valid),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    // Output must be the previous cycle's transfer, one-for-one.
    always @(negedge clk) begin
        if (lat_en) begin
            if (pix_valid !== prev_x) lat_bad++;
            else if (pix_valid && (pix_data !== prev_d)) lat_bad++;
        end
        prev_x = s_valid & s_ready;
        prev_d = s_data;
        if (pix_valid === 1'b1) begin
            pv_cnt++;
            if (pix_data == '0) pv_zero++;
        end
        if ((s_valid & s_ready) === 1'b1) xfer_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        logic x;
        @(negedge clk);
        x = s_valid & s_ready;
        @(posedge clk);
        #1;
        if (x === 1'b1) s_data = s_data + 1'b1;
        if (toggle) s_valid = ~s_valid;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_intr();
        intr = 1'b1;
        tick();
        intr = 1'b0;
        tick();
    endtask

    task automatic start_frame(input logic [1:0] m);
        s_data = '0;
        mode   = m;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat_en = 1'b1;
    endtask

    // From WAIT_INTR with all lines sent: two pad bursts, then optional core outputs.
    task automatic finish_frame(input int n_valid);
        lat_en = 1'b0;
        pulse_intr();
        ticks(10);
        pulse_intr();
        ticks(10);
        if (n_valid > 0) begin
            out_valid = 1'b1;
            ticks(n_valid);
            out_valid = 1'b0;
        end
        ticks(4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1);
    end

    initial begin
        ticks(3);
        check("rst_ready", s_ready, 0);
        check("rst_pvalid", pix_valid, 0);
        check("rst_pdata", pix_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_mode", mode_out, 0);
        rst_n = 1'b1;
        tick();

        // Frame 1: full sequence.
        s_valid = 1'b1;
        start_frame(2'd3);
        ticks(36);
        check("pf_xfers", xfer_cnt, 32);
        check("pf_pulses", pv_cnt, 32);
        check("pf_ready_low", s_ready, 0);
        check("pf_mode", mode_out, 3);
        check("pf_busy", busy, 1);
        for (int i = 0; i < 2; i++) begin
            x0 = xfer_cnt;
            pulse_intr();
            ticks(10);
            check("line_xfers", xfer_cnt - x0, 8);
            check("line_ready_low", s_ready, 0);
        end
        check("lines_pulses", pv_cnt, 48);
        check("lines_mode", mode_out, 3);
        lat_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            p0 = pv_cnt;
            z0 = pv_zero;
            pulse_intr();
            ticks(10);
            check("pad_pulses", pv_cnt - p0, 8);
            check("pad_zeros", pv_zero - z0, 8);
        end
        check("pad_no_xfer", xfer_cnt, 48);
        p0 = pv_cnt;
        pulse_intr();
        ticks(4);
        check("drain_no_pix", pv_cnt - p0, 0);
        check("drain_busy", busy, 1);
        check("drain_ready", s_ready, 0);
        out_valid = 1'b1;
        ticks(47);
        check("done_early", done_cnt, 0);
        check("busy_47", busy, 1);
        tick();
        out_valid = 1'b0;
        ticks(4);
        check("done_once", done_cnt, 1);
        check("done_idle", busy, 0);
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        ticks(3);
        check("extra_valid", done_cnt, 1);
        check("extra_busy", busy, 0);
        check("f1_latency", lat_bad, 0);

        // Frame 2: pend and overrun; outputs stream throughout to exercise saturation.
        out_valid = 1'b1;
        start_frame(2'd1);
        x0 = xfer_cnt;
        ticks(36);
        pulse_intr();
        pulse_intr();
        pulse_intr();
        check("ovr_err", err, 1);
        ticks(3);
        check("pend_wait", s_ready, 0);
        tick();
        check("pend_line", s_ready, 1);
        ticks(10);
        check("f2_xfers", xfer_cnt - x0, 48);
        check("f2_err_hold", err, 1);
        finish_frame(0);
        out_valid = 1'b0;
        check("sat_done", done_cnt, 2);
        check("sat_idle", busy, 0);
        check("err_sticky", err, 1);
        check("f2_mode", mode_out, 1);

        // Frame 3: gappy source, ignored start, then reset mid-line.
        start_frame(2'd2);
        check("start_clr_err", err, 0);
        ticks(36);
        toggle = 1'b1;
        x0 = xfer_cnt;
        pulse_intr();
        ticks(5);
        start = 1'b1;
        mode  = 2'd1;
        tick();
        start = 1'b0;
        ticks(20);
        toggle = 1'b0;
        check("gap_xfers", xfer_cnt - x0, 8);
        check("gap_mode", mode_out, 2);
        check("gap_ready", s_ready, 0);
        check("gap_last", pix_data, 39);
        check("gap_busy", busy, 1);
        s_valid = 1'b1;
        x0 = xfer_cnt;
        pulse_intr();
        ticks(2);
        rst_n = 1'b0;
        tick();
        check("mid_xfers", xfer_cnt - x0, 3);
        check("mid_ready", s_ready, 0);
        check("mid_pvalid", pix_valid, 0);
        check("mid_busy", busy, 0);
        check("mid_err", err, 0);
        check("mid_mode", mode_out, 0);
        rst_n = 1'b1;
        tick();
        check("all_latency", lat_bad, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
